// File: rtl/sha1_pkg.sv
// SHA-1 shared definitions: chaining-state IV, round constants, FSM states and the
// single-round step used by the unrolled datapath.
package sha1_pkg;

  localparam logic [159:0] SHA1_H0 = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                      32'h10325476, 32'hC3D2E1F0};
  localparam logic [31:0]  SHA1_K0 = 32'h5A827999;
  localparam logic [31:0]  SHA1_K1 = 32'h6ED9EBA1;
  localparam logic [31:0]  SHA1_K2 = 32'h8F1BBCDC;
  localparam logic [31:0]  SHA1_K3 = 32'hCA62C1D6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUNDS = 2'd1,
    ST_DONE   = 2'd2
  } sha1_state_e;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // One compression round on {a,b,c,d,e} (a in the top word) for round index t.
  function automatic logic [159:0] sha1_round(input logic [159:0] s,
                                              input logic [31:0]  w,
                                              input logic [6:0]   t);
    logic [31:0] a, b, c, d, e, f, k, tmp;
    {a, b, c, d, e} = s;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = SHA1_K0;
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = SHA1_K1;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = SHA1_K2;
    end else begin
      f = b ^ c ^ d;
      k = SHA1_K3;
    end
    tmp = rotl(a, 5) + f + e + k + w;
    return {tmp, a, rotl(b, 30), c, d};
  endfunction

endpackage

// File: rtl/sha1_w_sched.sv
// SHA-1 message schedule: 16-word sliding window, emits ROUNDS_PER_CYCLE words W_t..W_t+R-1
// combinationally each cycle; load wins over shift, no backpressure.
module sha1_w_sched
  import sha1_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_i,
  input  logic                            shift_i,
  input  logic [511:0]                    block_i,
  output logic [32*ROUNDS_PER_CYCLE-1:0]  w_o
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam int N = 16 + R;

  // Window word i lives at [32*i +: 32]; word 0 is the oldest (W_t).
  logic [511:0]    win_q, win_d;
  logic [32*N-1:0] ext;

  function automatic logic [32*N-1:0] expand(input logic [511:0] win);
    logic [32*N-1:0] x;
    x = '0;
    x[511:0] = win;
    for (int i = 16; i < N; i++) begin
      x[32*i +: 32] = rotl(x[32*(i-3) +: 32] ^ x[32*(i-8) +: 32] ^
                           x[32*(i-14) +: 32] ^ x[32*(i-16) +: 32], 1);
    end
    return x;
  endfunction

  assign ext = expand(win_q);
  assign w_o = ext[32*R-1:0];

  always_comb begin
    win_d = win_q;
    if (load_i) begin
      for (int i = 0; i < 16; i++) win_d[32*i +: 32] = block_i[511-32*i -: 32];
    end else if (shift_i) begin
      win_d = ext[32*R +: 512];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) win_q <= '0;
    else       win_q <= win_d;
  end

endmodule

// File: rtl/sha1_core_rpc.sv
// SHA-1 compression engine, R rounds per clock; ready low for 80/R+1 cycles per block,
// commands while busy are dropped (flagged on cmd_err when SHA1_CMD_ERR_EN is defined).
module sha1_core_rpc
  import sha1_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block,
  output logic         ready,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         cmd_err
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 5 || R == 8 || R == 10 || R == 16 || R == 20))
  begin : g_bad_rounds
    $error("sha1_core_rpc: ROUNDS_PER_CYCLE must be one of 1,2,4,5,8,10,16,20");
  end

  sha1_state_e     state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [159:0]    h_q, h_d;
  logic [159:0]    abcde_q, abcde_d, abcde_rnd;
  logic            dv_q, dv_d;
  logic [32*R-1:0] w_rnd;
  logic            accept;

  assign ready        = (state_q == ST_IDLE);
  assign accept       = ready && (init || next);
  assign digest       = h_q;
  assign digest_valid = dv_q;

  sha1_w_sched #(.ROUNDS_PER_CYCLE(R)) u_w_sched (
    .clk     (clk),
    .reset   (reset),
    .load_i  (accept),
    .shift_i (state_q == ST_ROUNDS),
    .block_i (block),
    .w_o     (w_rnd)
  );

  always_comb begin
    abcde_rnd = abcde_q;
    for (int j = 0; j < R; j++) begin
      abcde_rnd = sha1_round(abcde_rnd, w_rnd[32*j +: 32], cnt_q + 7'(j));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    abcde_d = abcde_q;
    dv_d    = dv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // init takes priority when both commands arrive together
          abcde_d = init ? SHA1_H0 : h_q;
          if (init) h_d = SHA1_H0;
          dv_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_ROUNDS;
        end
      end
      ST_ROUNDS: begin
        abcde_d = abcde_rnd;
        if (cnt_q == 7'(80 - R)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 7'(R);
        end
      end
      ST_DONE: begin
        for (int i = 0; i < 5; i++) h_d[32*i +: 32] = h_q[32*i +: 32] + abcde_q[32*i +: 32];
        dv_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      abcde_q <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      abcde_q <= abcde_d;
      dv_q    <= dv_d;
    end
  end

`ifdef SHA1_CMD_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept)                      err_d = 1'b0;
    else if (!ready && (init || next)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign cmd_err = err_q;
`else
  assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha1_core_rpc.sv
// Bench for sha1_core_rpc: three instances (R=1,4,20) exercised one at a time, digests
// checked through a scoreboard queue popped on each digest_valid rising edge.
module tb_sha1_core_rpc;

  localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_M1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_M2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_TWO = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

`ifdef SHA1_CMD_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    bit           chk;
    logic [159:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] blk;
  logic         init_v [3];
  logic         next_v [3];
  logic         rdy_v  [3];
  logic         dv_v   [3];
  logic         err_v  [3];
  logic [159:0] dig_v  [3];
  logic         dv_prev [3];

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sha1_core_rpc #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .init(init_v[0]), .next(next_v[0]), .block(blk),
    .ready(rdy_v[0]), .digest(dig_v[0]), .digest_valid(dv_v[0]), .cmd_err(err_v[0]));
  sha1_core_rpc #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset), .init(init_v[1]), .next(next_v[1]), .block(blk),
    .ready(rdy_v[1]), .digest(dig_v[1]), .digest_valid(dv_v[1]), .cmd_err(err_v[1]));
  sha1_core_rpc #(.ROUNDS_PER_CYCLE(20)) u_dut20 (
    .clk(clk), .reset(reset), .init(init_v[2]), .next(next_v[2]), .block(blk),
    .ready(rdy_v[2]), .digest(dig_v[2]), .digest_valid(dv_v[2]), .cmd_err(err_v[2]));

  function automatic int r_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 20;
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every digest_valid rise consumes the oldest expectation.
  initial for (int k = 0; k < 3; k++) dv_prev[k] = 1'b0;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dv_v[k] === 1'b1 && dv_prev[k] !== 1'b1) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("sb_unexpected_r%0d", r_of(k)), 160'd0, 160'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.chk) chk($sformatf("digest_r%0d", r_of(k)), dig_v[k], e.d);
        end
      end
      dv_prev[k] = dv_v[k];
    end
  end

  task automatic send(input int k, input bit do_init, input bit do_next, input logic [511:0] b,
                      input bit chk_d, input logic [159:0] exp_d, input bit disturb);
    int waitc;
    int lowcnt;
    waitc = 0;
    while (rdy_v[k] !== 1'b1 && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (rdy_v[k] !== 1'b1) chk("ready_wait_timeout", 160'd0, 160'd1);
    sb_q.push_back('{chk: chk_d, d: exp_d});
    init_v[k] = do_init;
    next_v[k] = do_next;
    blk       = b;
    @(negedge clk);
    init_v[k] = 1'b0;
    next_v[k] = 1'b0;
    chk($sformatf("err_clear_on_accept_r%0d", r_of(k)), 160'(err_v[k]), 160'd0);
    lowcnt = 0;
    while (rdy_v[k] !== 1'b1 && lowcnt < 300) begin
      lowcnt++;
      if (disturb && (lowcnt == 2 || lowcnt == 3)) begin
        init_v[k] = 1'b1;
        next_v[k] = (lowcnt == 3);
        blk       = {16{$urandom()}};
      end else begin
        init_v[k] = 1'b0;
        next_v[k] = 1'b0;
      end
      @(negedge clk);
    end
    chk($sformatf("ready_low_cycles_r%0d", r_of(k)), 160'(lowcnt), 160'(80 / r_of(k) + 1));
    chk($sformatf("dv_with_ready_r%0d", r_of(k)), 160'(dv_v[k]), 160'd1);
  endtask

  task automatic abort40(input int k);
    int waitc;
    waitc = 0;
    while (rdy_v[k] !== 1'b1 && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    init_v[k] = 1'b1;
    blk       = BLK_ABC;
    @(negedge clk);
    init_v[k] = 1'b0;
    repeat (40 / r_of(k)) @(negedge clk);
    chk($sformatf("busy_at_round40_r%0d", r_of(k)), 160'(rdy_v[k]), 160'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk($sformatf("abort_ready_r%0d", r_of(k)), 160'(rdy_v[k]), 160'd1);
    chk($sformatf("abort_dv_r%0d", r_of(k)), 160'(dv_v[k]), 160'd0);
    chk($sformatf("abort_digest_r%0d", r_of(k)), dig_v[k], 160'd0);
    chk($sformatf("abort_err_r%0d", r_of(k)), 160'(err_v[k]), 160'd0);
  endtask

  initial begin
    reset = 1'b1;
    blk   = '0;
    for (int k = 0; k < 3; k++) begin
      init_v[k] = 1'b0;
      next_v[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready_r%0d", r_of(k)), 160'(rdy_v[k]), 160'd1);
      chk($sformatf("rst_dv_r%0d", r_of(k)), 160'(dv_v[k]), 160'd0);
      chk($sformatf("rst_digest_r%0d", r_of(k)), dig_v[k], 160'd0);
      chk($sformatf("rst_err_r%0d", r_of(k)), 160'(err_v[k]), 160'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      send(k, 1'b1, 1'b0, BLK_ABC, 1'b1, DIG_ABC, 1'b0);
      send(k, 1'b1, 1'b0, BLK_M1, 1'b0, 160'd0, 1'b0);
      send(k, 1'b0, 1'b1, BLK_M2, 1'b1, DIG_TWO, 1'b0);
      send(k, 1'b1, 1'b0, BLK_ABC, 1'b1, DIG_ABC, 1'b1);
      chk($sformatf("cmd_err_set_r%0d", r_of(k)), 160'(err_v[k]), 160'(ERR_EN));
      repeat (2) @(negedge clk);
      chk($sformatf("cmd_err_sticky_r%0d", r_of(k)), 160'(err_v[k]), 160'(ERR_EN));
      chk($sformatf("dv_hold_r%0d", r_of(k)), 160'(dv_v[k]), 160'd1);
      abort40(k);
      send(k, 1'b1, 1'b0, BLK_ABC, 1'b1, DIG_ABC, 1'b0);
      send(k, 1'b1, 1'b1, BLK_ABC, 1'b1, DIG_ABC, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 160'(sb_q.size()), 160'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
